// File: rtl/tdm_demux1x16_pkg.sv
// Shared types and sizing for the 1-to-16 TDM serial demultiplexer.
package tdm_pkg;
   localparam int MAX_LANES = 16;
   localparam int LANE_W    = 4;

   typedef enum logic {
      IDLE    = 1'b0,
      COLLECT = 1'b1
   } state_t;
endpackage

// File: rtl/tdm_demux1x16_if.sv
// Serial-in / frame-out signal bundle of the TDM demultiplexer.
interface tdm_demux1x16_if;
   import tdm_pkg::*;

   logic                 din;
   logic                 din_valid;
   logic                 sof;
   logic [MAX_LANES-1:0] q;
   logic                 q_valid;
   logic [LANE_W-1:0]    lane_sel;
   logic                 busy;
   logic                 frame_err;

   modport master (
      output din, din_valid, sof,
      input  q, q_valid, lane_sel, busy, frame_err
   );

   modport slave (
      input  din, din_valid, sof,
      output q, q_valid, lane_sel, busy, frame_err
   );
endinterface

// File: rtl/tdm_demux1x16_lane_counter.sv
// Lane index counter: clear beats load-1 beats increment; tc flags the last lane.
module tdm_lane_counter
   import tdm_pkg::*;
#(
   parameter int LANES = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              load1,
   input  logic              en,
   output logic [LANE_W-1:0] cnt,
   output logic              tc
);
   localparam logic [LANE_W-1:0] LAST = LANE_W'(LANES - 1);

   logic [LANE_W-1:0] cnt_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)        cnt_reg <= '0;
      else if (clr)   cnt_reg <= '0;
      else if (load1) cnt_reg <= LANE_W'(1);
      else if (en)    cnt_reg <= cnt_reg + 1'b1;
   end

   assign cnt = cnt_reg;
   assign tc  = (cnt_reg == LAST);
endmodule

// File: rtl/tdm_demux1x16.sv
// Collects LANES serial bits (lane 0 marked by sof) into a parallel frame on q.
module tdm_demux1x16
   import tdm_pkg::*;
#(
   parameter int LANES = 16   // power of two, 2..16
) (
   input  logic         clk,
   input  logic         rst,
   tdm_demux1x16_if.slave bus
);
   state_t               state_reg, state_next;
   logic [LANES-2:0]     shadow_reg, shadow_next;
   logic [MAX_LANES-1:0] q_reg, q_next, frame_w;
   logic                 q_valid_reg, q_valid_next;
   logic                 frame_err_reg, frame_err_next;
   logic                 cnt_clr, cnt_load1, cnt_en, tc;
   logic                 shadow_we;
   logic [LANE_W-1:0]    shadow_idx, lane_sel;

   tdm_lane_counter #(.LANES(LANES)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (cnt_clr),
      .load1 (cnt_load1),
      .en    (cnt_en),
      .cnt   (lane_sel),
      .tc    (tc)
   );

   // The last lane bypasses the shadow so the frame lands on q on the same edge.
   for (genvar gi = 0; gi < MAX_LANES; gi++) begin : g_frame
      if (gi == LANES - 1) begin : g_last
         assign frame_w[gi] = bus.din;
      end else if (gi < LANES - 1) begin : g_shadow
         assign frame_w[gi] = shadow_reg[gi];
      end else begin : g_unused
         assign frame_w[gi] = 1'b0;
      end
   end

   for (genvar gi = 0; gi < LANES - 1; gi++) begin : g_wr
      assign shadow_next[gi] = (shadow_we && shadow_idx == LANE_W'(gi)) ? bus.din : shadow_reg[gi];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         shadow_reg    <= '0;
         q_reg         <= '0;
         q_valid_reg   <= 1'b0;
         frame_err_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         shadow_reg    <= shadow_next;
         q_reg         <= q_next;
         q_valid_reg   <= q_valid_next;
         frame_err_reg <= frame_err_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      q_next         = q_reg;
      q_valid_next   = 1'b0;
      frame_err_next = 1'b0;
      cnt_clr        = 1'b0;
      cnt_load1      = 1'b0;
      cnt_en         = 1'b0;
      shadow_we      = 1'b0;
      shadow_idx     = lane_sel;
      case (state_reg)
         IDLE: begin
            if (bus.din_valid && bus.sof) begin
               shadow_we  = 1'b1;
               shadow_idx = '0;
               cnt_load1  = 1'b1;
               state_next = COLLECT;
            end
         end
         COLLECT: begin
            if (bus.din_valid) begin
               if (bus.sof) begin
                  // Early sof: drop the partial frame and restart at lane 0.
                  frame_err_next = 1'b1;
                  shadow_we      = 1'b1;
                  shadow_idx     = '0;
                  cnt_load1      = 1'b1;
               end else if (tc) begin
                  q_next       = frame_w;
                  q_valid_next = 1'b1;
                  cnt_clr      = 1'b1;
                  state_next   = IDLE;
               end else begin
                  shadow_we = 1'b1;
                  cnt_en    = 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign bus.q         = q_reg;
   assign bus.q_valid   = q_valid_reg;
   assign bus.lane_sel  = lane_sel;
   assign bus.busy      = (state_reg == COLLECT);
   assign bus.frame_err = frame_err_reg;
endmodule
